// File: rtl/frame_streamer.sv
// Replays a frame from word-addressed result memory as a 32-bit sop/eop packet stream.
// Optional abort support is compiled in with `define TX_ABORT_EN.
module frame_streamer #(
  parameter int MAX_BYTES = 1536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [10:0] byte_len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_addr,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  output logic [31:0] data_out,
  output logic        valid,
  input  logic        ready,
  output logic        sop,
  output logic        eop,
  output logic [1:0]  empty,
  output logic [5:0]  error
);

  localparam int CW = $clog2(MAX_BYTES / 4 + 1);

`ifdef TX_ABORT_EN
  typedef enum logic [1:0] {IDLE, PRIME, SEND, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRIME, SEND} state_t;
  logic unused_abort;
  assign unused_abort = abort;
`endif

  state_t         state, state_next;
  logic [31:0]    base_q;
  logic [CW-1:0]  words_q;
  logic [CW-1:0]  issued;
  logic [CW-1:0]  beats;
  logic [1:0]     last_empty_q;
  logic           rd_pending;
  logic [31:0]    buf_mem [2];
  logic           wr_ptr, rd_ptr;
  logic [1:0]     count;
  logic           done_q;

  logic [10:0]    len_clamped;
  logic [CW-1:0]  words_in;
  logic [1:0]     empty_in;
  logic           pop;
  logic           last_beat;
  logic           flush;
  logic           done_next;
  logic           room;

  // Frame geometry from the requested length, clamped to the largest legal frame.
  always_comb begin
    len_clamped = (byte_len > 11'(MAX_BYTES)) ? 11'(MAX_BYTES) : byte_len;
    words_in    = CW'((12'(len_clamped) + 12'd3) >> 2);
    empty_in    = (~len_clamped[1:0]) + 2'd1;
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign rd_addr   = base_q + 32'(issued);
  assign last_beat = (beats == words_q - CW'(1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    valid      = 1'b0;
    data_out   = '0;
    sop        = 1'b0;
    eop        = 1'b0;
    empty      = '0;
    error      = '0;
    pop        = 1'b0;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (words_in == '0) done_next = 1'b1;
          else                state_next = PRIME;
        end
      end
      PRIME: begin
        if (rd_pending) state_next = SEND;
      end
      SEND: begin
        valid    = (count != 2'd0);
        data_out = valid ? buf_mem[rd_ptr] : '0;
        sop      = valid && (beats == '0);
        eop      = valid && last_beat;
        empty    = eop ? last_empty_q : 2'd0;
        pop      = valid && ready;
        if (pop && last_beat) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`ifdef TX_ABORT_EN
      ABORT: begin
        valid = 1'b1;
        eop   = 1'b1;
        error = 6'b000001;
        if (ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    // Keep buffered plus in-flight words at two or fewer after this cycle's pop.
    room = (({1'b0, count} + {2'b0, rd_pending} - {2'b0, pop}) < 3'd2);
    if ((state == PRIME || state == SEND) && issued < words_q && room)
      rd_en = 1'b1;

`ifdef TX_ABORT_EN
    // A frame finishing on this very beat wins over abort.
    if (abort && (state == PRIME || (state == SEND && !(pop && last_beat)))) begin
      rd_en = 1'b0;
      if (state == SEND && (beats != '0 || pop)) begin
        state_next = ABORT;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
`endif

    flush = (state_next != PRIME) && (state_next != SEND);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      words_q      <= '0;
      last_empty_q <= '0;
      issued       <= '0;
      beats        <= '0;
      rd_pending   <= 1'b0;
      count        <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= done_next;
      if (state == IDLE && start) begin
        base_q       <= base_addr;
        words_q      <= words_in;
        last_empty_q <= empty_in;
        issued       <= '0;
        beats        <= '0;
      end else begin
        if (rd_en) issued <= issued + CW'(1);
        if (pop)   beats  <= beats + CW'(1);
      end
      if (flush) begin
        rd_pending <= 1'b0;
        count      <= '0;
        wr_ptr     <= 1'b0;
        rd_ptr     <= 1'b0;
      end else begin
        rd_pending <= rd_en;
        if (rd_pending) wr_ptr <= ~wr_ptr;
        if (pop)        rd_ptr <= ~rd_ptr;
        count <= count + 2'(rd_pending) - 2'(pop);
      end
    end
  end

  // NOTE: buffer storage has no reset; count alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rd_pending && !flush) buf_mem[wr_ptr] <= rd_data;
  end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Memory-to-stream transmitter for the sniffer datapath: reads a captured frame out of the result memory (the same word-addressed memory the capture path writes) and replays it as a 32-bit packet stream using the same sop/eop/empty/error/valid/ready handshake the sniffer consumes. It serves as a loopback source for regression benches and as the egress path for forwarding flagged frames. A 2-entry internal buffer absorbs the memory read latency so backpressure never loses data.

## Interface
- MAX_BYTES, 1536: largest legal frame length in bytes; byte_len above this is clamped to MAX_BYTES.
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send a frame; honoured only when busy=0.
- base_addr  in  32  word address of the frame's first word; sampled with start.
- byte_len  in  11  frame length in bytes; sampled with start; 0 means no frame.
- abort  in  1  terminate the current frame (see Configuration).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a frame finishes (normal, aborted or zero-length).
- rd_addr  out  32  memory read address.
- rd_en  out  1  memory read strobe.
- rd_data  in  32  read data, valid exactly one cycle after rd_en.
- data_out  out  32  stream word; first byte in bits [31:24].
- valid  out  1  data_out and sideband are meaningful.
- ready  in  1  sink accepts the beat when valid&&ready (ready latency 0).
- sop  out  1  first beat of frame.
- eop  out  1  last beat of frame.
- empty  out  2  unused bytes in the eop beat (low-order bytes).
- error  out  6  error flags, only nonzero on the eop beat.

## Operation
- States: IDLE, PRIME, SEND, ABORT.
- IDLE: on start, latch base_addr, words = ceil(len/4), last_empty = (4 - len mod 4) mod 4. len=0 -> no beats, done next cycle, back to IDLE. Otherwise -> PRIME.
- PRIME: issue reads until the buffer holds the first word, then -> SEND.
- Read issue rule (PRIME and SEND): rd_en=1 when issued < words and (occupancy + in_flight - pop) < 2; rd_addr = base_addr + issued, incremented by 1 per read, 32-bit wrap-around allowed.
- SEND: valid = buffer non-empty. sop=1 on beat 0, eop=1 and empty=last_empty on beat words-1, both on a 1-word frame. Outputs hold stable while valid&&!ready.
- After the eop handshake: done pulses next cycle, busy drops with it, -> IDLE.
- start while busy=1 is ignored; base_addr and byte_len changes are ignored after sampling.
- ABORT (with TX_ABORT_EN): in-flight read and buffer are discarded. If sop was already accepted, emit one beat: data_out=0, eop=1, empty=0, error=6'b000001, held until ready; then done. If sop was not yet accepted, emit nothing; done next cycle.

## Timing
- Reset values: busy, done, rd_en, valid, sop, eop = 0; rd_addr, data_out = 0; empty, error = 0; state IDLE; buffer empty.
- start in cycle 0 -> rd_en in cycle 1 (rd_addr=base_addr) -> data captured at end of cycle 2 -> valid with sop in cycle 3.
- Sustained throughput is 1 beat/cycle with ready held high.
- ready low for N cycles -> no more than 2 words buffered, no reads issued while full, no word dropped or duplicated.
- abort and the eop handshake in the same cycle: the frame completes normally; abort is ignored.
- rst mid-frame: all outputs return to reset values immediately; no done pulse.

## Configuration
- TX_ABORT_EN defined: abort input active, ABORT state and error-beat behaviour present.
- Undefined: abort ignored, ABORT state absent, error tied to 0.

## Test plan
- byte_len=10, base_addr=0x100, ready=1 -> 3 beats from 0x100..0x102, sop on beat 0, eop with empty=2 on beat 2, valid first in cycle 3, done 1 cycle after eop.
- byte_len=4 -> single beat with sop=1, eop=1, empty=0; byte_len=0 -> no beats, done in cycle 1.
- byte_len=64, ready toggling 1/0 every cycle, plus ready low for 5 cycles -> 16 beats in address order, data stable while stalled, no more than 2 reads outstanding.
- TX_ABORT_EN, byte_len=40, abort after beat 3 -> one extra beat eop=1, error=6'b000001, data_out=0, then done; no further rd_en.
- start again while busy, and rst asserted at beat 5 -> second start ignored; after rst all outputs 0, no done; a new start afterwards sends a clean frame.
- base_addr=0xFFFFFFFF, byte_len=8 -> reads at 0xFFFFFFFF then 0x00000000.
